mmcm_drp_ctrl: RTL and testbench

MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

---
 rtl/mmcm_drp_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mmcm_drp_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmcm_drp_ctrl
// Purpose  : Sequences masked read-modify-write DRP updates to an MMCM. The
//            MMCM is held in reset for the updates and then released, and the
//            controller waits for a synchronized lock before it reports done.
// Options  : MMCM_DRP_READBACK_EN adds a verify read after each DRP write.
// Revision : 1.0 - initial release
// ============================================================================
module mmcm_drp_ctrl #(
    parameter int DRDY_TIMEOUT_p = 64,
    parameter int LOCK_TIMEOUT_p = 100000,
    parameter int RST_HOLD_p     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [6:0]  i_req_addr,
    input  logic [15:0] i_req_mask,
    input  logic [15:0] i_req_data,
    input  logic        i_req_last,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    output logic [6:0]  o_drp_daddr,
    output logic [15:0] o_drp_di,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic        o_mmcm_rst,
    input  logic        i_mmcm_locked,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int HOLD_W = $clog2(RST_HOLD_p + 1);
    localparam int DRDY_W = $clog2(DRDY_TIMEOUT_p + 1);
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT_p + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_p - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD_p);
    localparam logic [DRDY_W-1:0] DRDY_LAST = DRDY_W'(DRDY_TIMEOUT_p - 1);
    localparam logic [DRDY_W-1:0] DRDY_MAX  = DRDY_W'(DRDY_TIMEOUT_p);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT_p - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_TIMEOUT_p);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HOLD      = 4'd1,
        S_RD        = 4'd2,
        S_RD_WAIT   = 4'd3,
        S_WR        = 4'd4,
        S_WR_WAIT   = 4'd5,
`ifdef MMCM_DRP_READBACK_EN
        S_VFY       = 4'd6,
        S_VFY_WAIT  = 4'd7,
`endif
        S_NEXT      = 4'd8,
        S_RELEASE   = 4'd9,
        S_LOCK_WAIT = 4'd10
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         addr_q, addr_d;
    logic [15:0]        mask_q, mask_d;
    logic [15:0]        data_q, data_d;
    logic               last_q, last_d;
    logic [15:0]        di_q, di_d;
    logic               mmcm_rst_q, mmcm_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [DRDY_W-1:0]  drdy_cnt_q, drdy_cnt_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic               lock_meta_q, lock_sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            di_q        <= '0;
            mmcm_rst_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_cnt_q  <= '0;
            drdy_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            last_q      <= last_d;
            di_q        <= di_d;
            mmcm_rst_q  <= mmcm_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            hold_cnt_q  <= hold_cnt_d;
            drdy_cnt_q  <= drdy_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_meta_q <= i_mmcm_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        data_d     = data_q;
        last_d     = last_q;
        di_d       = di_q;
        mmcm_rst_d = mmcm_rst_q;
        done_d     = 1'b0;
        err_d      = err_q;
        hold_cnt_d = hold_cnt_q;
        drdy_cnt_d = drdy_cnt_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    addr_d     = i_req_addr;
                    mask_d     = i_req_mask;
                    data_d     = i_req_data;
                    last_d     = i_req_last;
                    err_d      = 1'b0;
                    mmcm_rst_d = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RD;
                end else begin
                    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
                end
            end
            S_RD: begin
                drdy_cnt_d = '0;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_drp_drdy) begin
                    // Mask bit set keeps the current register bit.
                    di_d    = (i_drp_do & mask_q) | (data_q & ~mask_q);
                    state_d = S_WR;
                end else if (drdy_cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    drdy_cnt_d = (drdy_cnt_q == DRDY_MAX) ? drdy_cnt_q : drdy_cnt_q + 1'b1;
                end
            end
            S_WR: begin
                drdy_cnt_d = '0;
                state_d    = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (i_drp_drdy) begin
`ifdef MMCM_DRP_READBACK_EN
                    state_d = S_VFY;
`else
                    state_d = last_q ? S_RELEASE : S_NEXT;
`endif
                end else if (drdy_cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    drdy_cnt_d = (drdy_cnt_q == DRDY_MAX) ? drdy_cnt_q : drdy_cnt_q + 1'b1;
                end
            end
`ifdef MMCM_DRP_READBACK_EN
            S_VFY: begin
                drdy_cnt_d = '0;
                state_d    = S_VFY_WAIT;
            end
            S_VFY_WAIT: begin
                if (i_drp_drdy) begin
                    // A verify miscompare is reported but does not stop the sequence.
                    if (i_drp_do != di_q) begin
                        err_d = 1'b1;
                    end
                    state_d = last_q ? S_RELEASE : S_NEXT;
                end else if (drdy_cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    drdy_cnt_d = (drdy_cnt_q == DRDY_MAX) ? drdy_cnt_q : drdy_cnt_q + 1'b1;
                end
            end
`endif
            S_NEXT: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    mask_d  = i_req_mask;
                    data_d  = i_req_data;
                    last_d  = i_req_last;
                    state_d = S_RD;
                end
            end
            S_RELEASE: begin
                mmcm_rst_d = 1'b0;
                lock_cnt_d = '0;
                state_d    = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                if (lock_sync_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_req_ready = (state_q == S_IDLE) || (state_q == S_NEXT);
    assign o_busy      = (state_q != S_IDLE);
`ifdef MMCM_DRP_READBACK_EN
    assign o_drp_den   = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_VFY);
`else
    assign o_drp_den   = (state_q == S_RD) || (state_q == S_WR);
`endif
    assign o_drp_dwe   = (state_q == S_WR);
    assign o_drp_daddr = addr_q;
    assign o_drp_di    = di_q;
    assign o_mmcm_rst  = mmcm_rst_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_ctrl.sv
`default_nettype none
// Directed bench for mmcm_drp_ctrl: DRP slave and MMCM lock models, negedge monitor,
// immediate-assertion checks against hand-computed values.
module tb_mmcm_drp_ctrl;

`ifdef MMCM_DRP_READBACK_EN
    localparam int DEN_PER_ENTRY = 3;
`else
    localparam int DEN_PER_ENTRY = 2;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [6:0]  i_req_addr = '0;
    logic [15:0] i_req_mask = '0;
    logic [15:0] i_req_data = '0;
    logic        i_req_last = 1'b0;
    logic        o_drp_den;
    logic        o_drp_dwe;
    logic [6:0]  o_drp_daddr;
    logic [15:0] o_drp_di;
    logic [15:0] i_drp_do = '0;
    logic        i_drp_drdy = 1'b0;
    logic        o_mmcm_rst;
    logic        i_mmcm_locked = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    mmcm_drp_ctrl #(
        .DRDY_TIMEOUT_p (64),
        .LOCK_TIMEOUT_p (50),
        .RST_HOLD_p     (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_addr    (i_req_addr),
        .i_req_mask    (i_req_mask),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .o_drp_den     (o_drp_den),
        .o_drp_dwe     (o_drp_dwe),
        .o_drp_daddr   (o_drp_daddr),
        .o_drp_di      (o_drp_di),
        .i_drp_do      (i_drp_do),
        .i_drp_drdy    (i_drp_drdy),
        .o_mmcm_rst    (o_mmcm_rst),
        .i_mmcm_locked (i_mmcm_locked),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input bit ok);
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    // Model controls, written only by the stimulus block
    int lat        = 2;
    bit rd_noresp  = 1'b0;
    bit corrupt    = 1'b0;
    bit lock_en    = 1'b1;
    int lock_delay = 20;

    // Model / monitor state, written only by the negedge process
    logic [15:0] mem [128];
    bit          written [128];
    int          pend = 0;
    logic [6:0]  pend_addr = '0;
    bit          pend_rd = 1'b0;
    bit          last_wr = 1'b0;
    logic [15:0] rdata;
    int          lock_ctr = 0;
    int          den_cyc = 0, wr_cnt = 0, done_cnt = 0, rst_falls = 0, wr_at_fall = 0;
    int          overlap = 0, pulse_double = 0, run_at_den = 0, rst_run = 0;
    bit          armed = 1'b0, prev_rst = 1'b0, prev_dwe = 1'b0, prev_den = 1'b0;
    logic [6:0]  wr_addr [16];
    logic [15:0] wr_data [16];

    always @(negedge i_clk) begin
        i_drp_drdy = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                i_drp_drdy = 1'b1;
                if (pend_rd) begin
                    rdata = written[pend_addr] ? mem[pend_addr] : 16'h1234;
                    if (corrupt && last_wr) rdata = rdata ^ 16'h0001;
                    i_drp_do = rdata;
                    last_wr  = 1'b0;
                end else begin
                    last_wr = 1'b1;
                end
            end
        end
        if (o_drp_den) begin
            den_cyc++;
            if (pend > 0) overlap++;
            if (armed) begin
                run_at_den = rst_run;
                armed      = 1'b0;
            end
            if (o_drp_dwe) begin
                mem[o_drp_daddr]     = o_drp_di;
                written[o_drp_daddr] = 1'b1;
                wr_addr[wr_cnt % 16] = o_drp_daddr;
                wr_data[wr_cnt % 16] = o_drp_di;
                wr_cnt++;
            end
            pend      = (rd_noresp && !o_drp_dwe) ? 0 : lat;
            pend_addr = o_drp_daddr;
            pend_rd   = !o_drp_dwe;
        end
        if ((o_drp_dwe && prev_dwe) || (o_drp_den && prev_den)) pulse_double++;
        prev_dwe = o_drp_dwe;
        prev_den = o_drp_den;
        if (o_done) done_cnt++;
        if (prev_rst && !o_mmcm_rst) begin
            rst_falls++;
            wr_at_fall = wr_cnt;
        end
        if (o_mmcm_rst) begin
            if (rst_run == 0) armed = 1'b1;
            rst_run++;
        end else begin
            rst_run = 0;
        end
        prev_rst = o_mmcm_rst;
        if (o_mmcm_rst || !lock_en) begin
            lock_ctr      = 0;
            i_mmcm_locked = 1'b0;
        end else if (lock_ctr >= lock_delay) begin
            i_mmcm_locked = 1'b1;
        end else begin
            lock_ctr++;
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                        input logic l);
        int n;
        n = 0;
        i_req_addr  = a;
        i_req_mask  = m;
        i_req_data  = d;
        i_req_last  = l;
        i_req_valid = 1'b1;
        while (!o_req_ready && n < 500) begin
            tick();
            n++;
        end
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int n;
        n    = 0;
        seen = 1'b0;
        while (!o_done && n < budget) begin
            tick();
            n++;
        end
        seen = o_done;
    endtask

    task automatic wait_ready(input int budget, output bit seen);
        int n;
        n = 0;
        while (!o_req_ready && n < budget) begin
            tick();
            n++;
        end
        seen = o_req_ready;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_ready"}, o_req_ready === 1'b1);
        chk({pfx, "_den"},   o_drp_den   === 1'b0);
        chk({pfx, "_dwe"},   o_drp_dwe   === 1'b0);
        chk({pfx, "_daddr"}, o_drp_daddr === 7'h00);
        chk({pfx, "_di"},    o_drp_di    === 16'h0000);
        chk({pfx, "_mrst"},  o_mmcm_rst  === 1'b0);
        chk({pfx, "_busy"},  o_busy      === 1'b0);
        chk({pfx, "_done"},  o_done      === 1'b0);
        chk({pfx, "_err"},   o_err       === 1'b0);
    endtask

    initial begin
        int d0, w0, c0, f0, n;
        bit seen;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        i_rst = 1'b0;
        tick();

        // Single entry: 0x1234 read, keep top nibble -> 0x1041
        d0 = done_cnt; w0 = wr_cnt; c0 = den_cyc;
        send(7'h08, 16'hF000, 16'h0041, 1'b1);
        wait_done(300, seen);
        chk("t1_done_seen", seen === 1'b1);
        chk("t1_err_at_done", o_err === 1'b0);
        repeat (3) tick();
        chk("t1_wr_count", (wr_cnt - w0) === 1);
        chk("t1_wr_addr", wr_addr[w0 % 16] === 7'h08);
        chk("t1_wr_data", wr_data[w0 % 16] === 16'h1041);
        chk("t1_di_out", o_drp_di === 16'h1041);
        chk("t1_rst_hold_cycles", run_at_den === 4);
        chk("t1_done_count", (done_cnt - d0) === 1);
        chk("t1_den_cycles", (den_cyc - c0) === DEN_PER_ENTRY);
        chk("t1_busy_after", o_busy === 1'b0);

        // Three entries with 10-cycle valid gaps
        d0 = done_cnt; w0 = wr_cnt; f0 = rst_falls;
        send(7'h10, 16'hF000, 16'h0041, 1'b0);
        wait_ready(200, seen);
        chk("t2_next1_ready", seen === 1'b1);
        chk("t2_next1_mrst", o_mmcm_rst === 1'b1);
        repeat (10) tick();
        chk("t2_gap1_mrst", o_mmcm_rst === 1'b1);
        chk("t2_gap1_busy", o_busy === 1'b1);
        send(7'h11, 16'h00FF, 16'hAB00, 1'b0);
        wait_ready(200, seen);
        chk("t2_next2_ready", seen === 1'b1);
        repeat (10) tick();
        chk("t2_gap2_mrst", o_mmcm_rst === 1'b1);
        send(7'h12, 16'h0000, 16'h5A5A, 1'b1);
        wait_done(300, seen);
        chk("t2_done_seen", seen === 1'b1);
        repeat (3) tick();
        chk("t2_wr_count", (wr_cnt - w0) === 3);
        chk("t2_addr0", wr_addr[w0 % 16] === 7'h10);
        chk("t2_data0", wr_data[w0 % 16] === 16'h1041);
        chk("t2_addr1", wr_addr[(w0 + 1) % 16] === 7'h11);
        chk("t2_data1", wr_data[(w0 + 1) % 16] === 16'hAB34);
        chk("t2_addr2", wr_addr[(w0 + 2) % 16] === 7'h12);
        chk("t2_data2", wr_data[(w0 + 2) % 16] === 16'h5A5A);
        chk("t2_rst_falls", (rst_falls - f0) === 1);
        chk("t2_wr_before_fall", (wr_at_fall - w0) === 3);
        chk("t2_done_count", (done_cnt - d0) === 1);
        chk("t2_err", o_err === 1'b0);

        // Read never answered: DEN cycle + 64 wait cycles, then err visible
        rd_noresp = 1'b1;
        d0 = done_cnt; w0 = wr_cnt; f0 = rst_falls;
        send(7'h20, 16'h0000, 16'hFFFF, 1'b1);
        n = 0;
        while (!o_drp_den && n < 50) begin
            tick();
            n++;
        end
        chk("t3_den_seen", o_drp_den === 1'b1);
        n = 0;
        while (!o_err && n < 200) begin
            tick();
            n++;
        end
        chk("t3_err_latency", n === 65);
        wait_done(200, seen);
        chk("t3_done_seen", seen === 1'b1);
        repeat (3) tick();
        rd_noresp = 1'b0;
        chk("t3_no_write", (wr_cnt - w0) === 0);
        chk("t3_rst_falls", (rst_falls - f0) === 1);
        chk("t3_done_count", (done_cnt - d0) === 1);
        chk("t3_err_sticky", o_err === 1'b1);

        // Lock never arrives: done 50 cycles after release
        lock_en = 1'b0;
        w0 = wr_cnt;
        send(7'h30, 16'hFFFF, 16'h0000, 1'b1);
        chk("t4_err_cleared", o_err === 1'b0);
        n = 0;
        while (o_mmcm_rst && n < 300) begin
            tick();
            n++;
        end
        chk("t4_released", o_mmcm_rst === 1'b0);
        n = 0;
        while (!o_done && n < 200) begin
            tick();
            n++;
        end
        chk("t4_lock_timeout", n === 50);
        chk("t4_err", o_err === 1'b1);
        tick();
        chk("t4_done_pulse_width", o_done === 1'b0);
        chk("t4_wr_data", wr_data[w0 % 16] === 16'h1234);
        lock_en = 1'b1;
        repeat (3) tick();

        // Asynchronous reset during WR_WAIT
        lat = 6;
        send(7'h40, 16'hFF00, 16'h00CD, 1'b1);
        n = 0;
        while (!o_drp_dwe && n < 100) begin
            tick();
            n++;
        end
        chk("t5_dwe_seen", o_drp_dwe === 1'b1);
        tick();
        d0 = done_cnt;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("t5");
        repeat (3) tick();
        i_rst = 1'b0;
        repeat (20) tick();
        chk("t5_no_done", (done_cnt - d0) === 0);
        chk("t5_idle_ready", o_req_ready === 1'b1);
        lat = 2;
        w0 = wr_cnt; d0 = done_cnt;
        send(7'h41, 16'h0000, 16'hBEEF, 1'b1);
        wait_done(300, seen);
        chk("t5_resume_done", seen === 1'b1);
        chk("t5_resume_err", o_err === 1'b0);
        repeat (3) tick();
        chk("t5_resume_data", wr_data[w0 % 16] === 16'hBEEF);
        chk("t5_resume_done_count", (done_cnt - d0) === 1);

`ifdef MMCM_DRP_READBACK_EN
        // Readback corrupted in bit 0
        corrupt = 1'b1;
        d0 = done_cnt; w0 = wr_cnt;
        send(7'h50, 16'h0000, 16'h0F0F, 1'b1);
        wait_done(300, seen);
        chk("t6_done_seen", seen === 1'b1);
        chk("t6_err", o_err === 1'b1);
        repeat (3) tick();
        corrupt = 1'b0;
        chk("t6_wr_data", wr_data[w0 % 16] === 16'h0F0F);
        chk("t6_done_count", (done_cnt - d0) === 1);
`endif

        chk("pulse_single_cycle", pulse_double === 0);
        chk("no_den_outstanding", overlap === 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
